// File: rtl/msg_scroll_sched.sv
// Message scroll scheduler: round-robin arbitration among message requesters,
// then streams the winner's characters through a shifting display window and
// flushes it back to blank before releasing the window.
module msg_scroll_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CHAR_W  = 5,
  parameter int unsigned WIN_CH  = 8,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic                         sec_clock,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [5:0]                   rom_len,
  input  logic [CHAR_W-1:0]            rom_char,
  output logic [$clog2(NUM_REQ)-1:0]   rom_sel,
  output logic [$clog2(MAX_LEN)-1:0]   rom_addr,
  output logic [WIN_CH*CHAR_W-1:0]     instruction,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         done,
  output logic                         abort
);

  localparam int unsigned SEL_W  = $clog2(NUM_REQ);
  localparam int unsigned ADDR_W = $clog2(MAX_LEN);
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned PAD_W  = $clog2(WIN_CH);
  localparam int unsigned WIN_W  = WIN_CH * CHAR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   owner, owner_nxt;
  logic [SEL_W-1:0]   last_grant, last_grant_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [ADDR_W-1:0]  idx, idx_nxt;
  logic [PAD_W-1:0]   pad, pad_nxt;
  logic               aborted, aborted_nxt;
  logic [WIN_W-1:0]   instruction_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               busy_nxt, done_nxt, abort_nxt;

  logic [SEL_W-1:0]   cand;
  logic               cand_valid;
  logic [SEL_W-1:0]   probe;
  logic [LEN_W-1:0]   len_clamped;

  // Round-robin candidate: first requester after last_grant, wrapping.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    probe      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      probe = SEL_W'((32'(last_grant) + i) % NUM_REQ);
      if (!cand_valid && req[probe]) begin
        cand_valid = 1'b1;
        cand       = probe;
      end
    end
  end

  // The ROM is asynchronous, so its select follows the candidate while idle
  // to make the winner's length available in the grant cycle.
  assign rom_sel     = (state == IDLE) ? cand : owner;
  assign len_clamped = (rom_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : rom_len;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_grant_nxt  = last_grant;
    len_nxt         = len;
    idx_nxt         = idx;
    pad_nxt         = pad;
    aborted_nxt     = aborted;
    instruction_nxt = instruction;
    grant_nxt       = grant;
    done_nxt        = 1'b0;
    abort_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        instruction_nxt = '0;
        idx_nxt         = '0;
        pad_nxt         = '0;
        aborted_nxt     = 1'b0;
        if (cand_valid) begin
          owner_nxt = cand;
          len_nxt   = len_clamped;
          grant_nxt = NUM_REQ'(1) << cand;
          state_nxt = (rom_len == '0) ? FLUSH : SCROLL;
        end
      end

      SCROLL: begin
        if (!req[owner]) begin
          // Requester withdrew: keep the window as is and blank it out.
          aborted_nxt = 1'b1;
          idx_nxt     = '0;
          pad_nxt     = '0;
          state_nxt   = FLUSH;
        end else begin
          instruction_nxt = {instruction[WIN_W-CHAR_W-1:0], rom_char};
          if (LEN_W'(idx) == len - LEN_W'(1)) begin
            idx_nxt   = '0;
            pad_nxt   = '0;
            state_nxt = FLUSH;
          end else begin
            idx_nxt = idx + ADDR_W'(1);
          end
        end
      end

      FLUSH: begin
        instruction_nxt = {instruction[WIN_W-CHAR_W-1:0], {CHAR_W{1'b0}}};
        if (pad == PAD_W'(WIN_CH - 1)) begin
          pad_nxt        = '0;
          grant_nxt      = '0;
          last_grant_nxt = owner;
          done_nxt       = !aborted;
          abort_nxt      = aborted;
          state_nxt      = IDLE;
        end else begin
          pad_nxt = pad + PAD_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge sec_clock) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      last_grant  <= SEL_W'(NUM_REQ - 1);
      len         <= '0;
      idx         <= '0;
      pad         <= '0;
      aborted     <= 1'b0;
      instruction <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_grant  <= last_grant_nxt;
      len         <= len_nxt;
      idx         <= idx_nxt;
      pad         <= pad_nxt;
      aborted     <= aborted_nxt;
      instruction <= instruction_nxt;
      grant       <= grant_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      abort       <= abort_nxt;
    end
  end

  assign rom_addr = idx;

endmodule

// File: tb/tb_msg_scroll_sched.sv
// Scoreboard bench for msg_scroll_sched: a message-level model predicts the
// window contents per busy cycle and the outcome of every message.
module tb_msg_scroll_sched;

  logic        sec_clock = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [5:0]  rom_len;
  logic [4:0]  rom_char;
  logic [1:0]  rom_sel;
  logic [4:0]  rom_addr;
  logic [39:0] instruction;
  logic [3:0]  grant;
  logic        busy, done, abort;

  logic [4:0]  rom_mem  [4][32];
  logic [5:0]  rom_lens [4];

  typedef struct {
    logic [3:0] grant;
    bit         is_abort;
    int         cyc;
  } rec_t;

  logic [39:0] exp_win_q [$];
  rec_t        rec_q     [$];

  int   checks = 0;
  int   errors = 0;
  int   lg;
  bit   mon_en;
  bit   mon_active;
  int   mon_cycles;
  logic [3:0] mon_grant;

  always #5 sec_clock = ~sec_clock;

  assign rom_len  = rom_lens[rom_sel];
  assign rom_char = rom_mem[rom_sel][rom_addr];

  msg_scroll_sched dut (
    .sec_clock   (sec_clock),
    .rst         (rst),
    .req         (req),
    .rom_len     (rom_len),
    .rom_char    (rom_char),
    .rom_sel     (rom_sel),
    .rom_addr    (rom_addr),
    .instruction (instruction),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .abort       (abort)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Round-robin winner from the model's last grant.
  function automatic int rr_pick(input logic [3:0] r);
    int p;
    int res;
    res = -1;
    for (int i = 4; i >= 1; i--) begin
      p = (lg + i) % 4;
      if (r[p[1:0]]) res = p;
    end
    return res;
  endfunction

  // Expected window per busy cycle: the last 8 characters of the stream seen
  // so far (chars then zero padding), newest in the low slot; an abort costs
  // one cycle with no shift.
  task automatic push_expect(input int w, input int k);
    int n, cyc, m;
    logic [4:0]  s [48];
    logic [39:0] wv;
    rec_t        rec;
    n = (rom_lens[w] > 6'd32) ? 32 : int'(rom_lens[w]);
    for (int i = 0; i < 48; i++) s[i] = 5'd0;
    if (k < 0) begin
      for (int i = 0; i < n; i++) s[i] = rom_mem[w][i];
      cyc = n + 8;
    end else begin
      for (int i = 0; i < k; i++) s[i] = rom_mem[w][i];
      cyc = k + 9;
    end
    for (int t = 0; t < cyc; t++) begin
      m  = (k >= 0 && t > k) ? t - 1 : t;
      wv = '0;
      for (int j = 0; j < 8; j++)
        if (m - 1 - j >= 0) wv[5*j +: 5] = s[m-1-j];
      exp_win_q.push_back(wv);
    end
    rec.grant    = 4'(1 << w);
    rec.is_abort = (k >= 0);
    rec.cyc      = cyc;
    rec_q.push_back(rec);
  endtask

  // Pops expectations whenever the DUT is busy or ends a message.
  task automatic monitor_loop();
    rec_t        r;
    logic [39:0] ew;
    forever begin
      @(negedge sec_clock);
      if (!mon_en) begin
        mon_active = 1'b0;
        mon_cycles = 0;
      end else if (busy) begin
        if (!mon_active) begin
          mon_active = 1'b1;
          mon_cycles = 0;
          mon_grant  = grant;
        end else begin
          check("grant_hold", 64'(grant), 64'(mon_grant));
        end
        if (exp_win_q.size() == 0) begin
          bound_fail("window_unexpected_busy");
        end else begin
          ew = exp_win_q.pop_front();
          check("window", 64'(instruction), 64'(ew));
        end
        mon_cycles++;
      end else if (done || abort) begin
        if (rec_q.size() == 0) begin
          bound_fail("unexpected_end_pulse");
        end else begin
          r = rec_q.pop_front();
          check("msg_grant", 64'(mon_grant), 64'(r.grant));
          check("msg_kind", 64'({done, abort}), r.is_abort ? 64'd1 : 64'd2);
          check("msg_cycles", 64'(mon_cycles), 64'(r.cyc));
          check("end_window", 64'(instruction), 64'd0);
          check("end_grant", 64'(grant), 64'd0);
        end
        mon_active = 1'b0;
      end else begin
        check("idle_window", 64'(instruction), 64'd0);
        check("idle_grant", 64'(grant), 64'd0);
        check("idle_addr", 64'(rom_addr), 64'd0);
      end
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    req    = '0;
    @(posedge sec_clock);
    @(negedge sec_clock);
    exp_win_q.delete();
    rec_q.delete();
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_rom_sel", 64'(rom_sel), 64'd0);
    req = 4'b1111;
    #1 check("rst_rr_all", 64'(rom_sel), 64'd0);
    req = 4'b0110;
    #1 check("rst_rr_mid", 64'(rom_sel), 64'd1);
    req = '0;
    @(negedge sec_clock);
    rst    = 1'b0;
    lg     = 3;
    mon_en = 1'b1;
  endtask

  task automatic randomize_rom();
    int c;
    for (int r = 0; r < 4; r++) begin
      c = int'($urandom_range(0, 9));
      rom_lens[r] = (c == 0) ? 6'd0 :
                    (c < 5)  ? 6'($urandom_range(1, 8)) :
                    (c < 8)  ? 6'($urandom_range(9, 32)) :
                               6'($urandom_range(33, 63));
      for (int a = 0; a < 32; a++) rom_mem[r][a] = 5'($urandom);
    end
  endtask

  // One message; k_sel >= 0 drops the owner's request after k_sel characters.
  task automatic run_msg(input logic [3:0] r, input int k_sel);
    int w, n, k, t;
    logic [3:0] ob;
    w  = rr_pick(r);
    n  = (rom_lens[w] > 6'd32) ? 32 : int'(rom_lens[w]);
    k  = (k_sel >= 0 && n > 0) ? ((k_sel < n) ? k_sel : n - 1) : -1;
    ob = 4'(1 << w);
    push_expect(w, k);
    lg  = w;
    req = r;
    @(posedge sec_clock);
    if (k >= 0) begin
      repeat (k) begin
        @(negedge sec_clock);
        req = 4'($urandom) | ob;
        @(posedge sec_clock);
      end
      @(negedge sec_clock);
      req = 4'($urandom) & ~ob;
    end
    t = 0;
    forever begin
      @(negedge sec_clock);
      if (done || abort) break;
      if (t > 100) begin
        bound_fail("msg_end_timeout");
        break;
      end
      t++;
      req = 4'($urandom) | ob;
    end
    req = '0;
  endtask

  initial begin
    int t;
    int w;
    rst    = 1'b1;
    req    = '0;
    mon_en = 1'b0;
    lg     = 3;
    for (int r = 0; r < 4; r++) begin
      rom_lens[r] = 6'd0;
      for (int a = 0; a < 32; a++) rom_mem[r][a] = 5'd0;
    end
    fork
      monitor_loop();
    join_none

    do_reset();

    // Three-character message from requester 0.
    rom_lens[0]    = 6'd3;
    rom_mem[0][0]  = 5'b10101;
    rom_mem[0][1]  = 5'b10011;
    rom_mem[0][2]  = 5'b00100;
    run_msg(4'b0001, -1);

    // Zero-length message.
    @(negedge sec_clock);
    rom_lens[0] = 6'd0;
    run_msg(4'b0001, -1);

    // Over-long message is clamped to 32 characters.
    @(negedge sec_clock);
    rom_lens[1] = 6'd40;
    for (int a = 0; a < 32; a++) rom_mem[1][a] = 5'(a + 1);
    run_msg(4'b0010, -1);

    // Request dropped after two characters.
    @(negedge sec_clock);
    rom_lens[0] = 6'd10;
    for (int a = 0; a < 32; a++) rom_mem[0][a] = 5'($urandom);
    run_msg(4'b0001, 2);

    // Back-to-back grants with requests held.
    do_reset();
    rom_lens[1] = 6'd1;
    rom_lens[3] = 6'd1;
    for (int p = 0; p < 3; p++) begin
      w = rr_pick(4'b1010);
      push_expect(w, -1);
      lg = w;
    end
    req = 4'b1010;
    for (int p = 0; p < 3; p++) begin
      t = 0;
      do begin
        @(negedge sec_clock);
        t++;
      end while (!(done || abort) && t < 60);
      if (!(done || abort)) bound_fail("b2b_timeout");
      if (p == 2) req = '0;
      else begin
        @(negedge sec_clock);
        check("b2b_regrant_busy", 64'(busy), 64'd1);
      end
    end

    // Reset during the fifth scroll cycle.
    @(negedge sec_clock);
    mon_en = 1'b0;
    rom_lens[0] = 6'd10;
    req = 4'b0001;
    @(posedge sec_clock);
    repeat (4) @(posedge sec_clock);
    @(negedge sec_clock);
    check("pre_rst_busy", 64'(busy), 64'd1);
    do_reset();
    rom_lens[2] = 6'd4;
    for (int a = 0; a < 32; a++) rom_mem[2][a] = 5'($urandom);
    run_msg(4'b0100, -1);

    // Randomized traffic with occasional aborts and idle gaps.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge sec_clock);
      randomize_rom();
      run_msg(4'($urandom_range(1, 15)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1);
    end

    repeat (3) @(negedge sec_clock);
    check("win_queue_drained", 64'(exp_win_q.size()), 64'd0);
    check("rec_queue_drained", 64'(rec_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msg_scroll_sched.md
MSG_SCROLL_SCHED -- requirements
Module: msg_scroll_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, 4, number of message requesters.
REQ-002 SHALL have parameter CHAR_W, 5, bits per character code.
REQ-003 SHALL have parameter WIN_CH, 8, characters in display window (window width = WIN_CH*CHAR_W = 40).
REQ-004 SHALL have parameter MAX_LEN, 32, maximum message length in characters.
REQ-005 SHALL have port sec_clock  input  1  scroll tick clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port req  input  NUM_REQ  level request per message source; held high while message wanted.
REQ-008 SHALL have port rom_len  input  6  length of message rom_sel, valid combinationally same cycle.
REQ-009 SHALL have port rom_char  input  CHAR_W  character at rom_sel/rom_addr, valid combinationally same cycle.
REQ-010 SHALL have port rom_sel  output  2  index of selected message source.
REQ-011 SHALL have port rom_addr  output  5  character index being fetched.
REQ-012 SHALL have port instruction  output  40  scrolling display window, newest character in [4:0].
REQ-013 SHALL have port grant  output  NUM_REQ  one-hot owner of the window; all-zero when idle.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse, message completed normally.
REQ-016 SHALL have port abort  output  1  one-cycle pulse, message cut short by request drop.

Function
REQ-017 SHALL implement FSM states IDLE, SCROLL, FLUSH; all outputs registered.
REQ-018 IDLE: rom_sel drives the arbitration candidate; if any req bit high, SHALL latch winner, clamp rom_len to MAX_LEN into len, set grant, go SCROLL with idx=0.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; after reset last_grant=NUM_REQ-1, so req[0] wins first.
REQ-020 If latched rom_len==0, SHALL skip SCROLL, go FLUSH directly (flush still 8 cycles, done at end).
REQ-021 SCROLL: rom_addr=idx, rom_sel=owner; each cycle SHALL shift window left by CHAR_W, inserting rom_char at [4:0], idx increments.
REQ-022 SCROLL SHALL last exactly len cycles; after shift of index len-1 go FLUSH with pad=0.
REQ-023 FLUSH: each cycle SHALL shift in 5'b00000; after WIN_CH (8) shifts window is all-zero, go IDLE.
REQ-024 On FLUSH exit SHALL pulse done (or abort, if aborted), clear grant, set last_grant=owner.
REQ-025 If req[owner] low during any SCROLL cycle, SHALL not shift that cycle, set aborted flag, go FLUSH; FLUSH completes normally, abort pulses instead of done.
REQ-026 req changes during FLUSH SHALL be ignored; no preemption by other requesters at any time.
REQ-027 In IDLE window SHALL hold all-zero; done/abort pulse cycle is an IDLE cycle and a new grant MAY be taken in it.
REQ-028 idx and pad counters SHALL never wrap; rom_addr held at 0 outside SCROLL.
REQ-029 Latency: req seen in IDLE -> grant/busy high next cycle; first character in instruction[4:0] one cycle later.

Reset
REQ-030 rst SHALL force IDLE, instruction=0, grant=0, busy=0, done=0, abort=0, rom_sel=0, rom_addr=0, idx=0, pad=0, last_grant=NUM_REQ-1.
REQ-031 rst mid-SCROLL or mid-FLUSH SHALL abandon the message with no done/abort pulse; rst has priority over all events.

Verification
REQ-032 req=4'b0001, rom_len=3, chars 10101,10011,00100 -> after 3 SCROLL cycles instruction[14:0]=10101_10011_00100, upper bits 0; 8 FLUSH cycles later instruction=0, done pulse, grant=0.
REQ-033 req=4'b1010 held, len=1 each -> grants in order 0010, 1000, 0010; each separated by 9 busy cycles.
REQ-034 req[0] drops after 2 SCROLL cycles of len=10 -> window holds 2 chars, then 8 zero shifts, abort pulse, done stays 0.
REQ-035 rom_len=40 -> exactly 32 SCROLL cycles, rom_addr 0..31, then FLUSH, done.
REQ-036 rom_len=0 -> 8 FLUSH cycles, instruction stays 0, done pulse.
REQ-037 rst asserted on 5th SCROLL cycle -> next cycle all outputs at reset values, no done/abort; then req=4'b0100 granted first-cycle as req[2] with last_grant=3 search order.
